// File: rtl/inout_sram_arbiter_pkg.sv
// ============================================================================
// Module  : inout_sram_arbiter_pkg
// Purpose : Shared types and constants for the two-port SRAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package inout_sram_arbiter_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/inout_sram_rr_pick.sv
// ============================================================================
// Module  : inout_sram_rr_pick
// Purpose : Two-input grant pick. Round-robin against the last-granted port,
//           or fixed priority (port 0 wins) when INOUT_ARB_FIXED_PRIO_EN is set.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inout_sram_rr_pick
  import inout_sram_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last_ptr,
  output logic [NUM_PORTS-1:0] gnt
);

`ifdef INOUT_ARB_FIXED_PRIO_EN
  logic unused_last_ptr;
  assign unused_last_ptr = last_ptr;
  assign gnt = {req[1] & ~req[0], req[0]};
`else
  // On contention the port that did not win last time goes next.
  assign gnt = (&req) ? (last_ptr ? 2'b01 : 2'b10) : req;
`endif

endmodule

`default_nettype wire

// File: rtl/inout_sram_arbiter.sv
// ============================================================================
// Module  : inout_sram_arbiter
// Purpose : Two-port arbiter onto a single-port SRAM with lock bursts capped
//           at MAX_BURST. Optional macro: INOUT_ARB_FIXED_PRIO_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inout_sram_arbiter
  import inout_sram_arbiter_pkg::*;
#(
  parameter int AW        = 18,
  parameter int DW        = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] we,
  input  logic [NUM_PORTS-1:0] lock,
  input  logic [AW-1:0]        addr0,
  input  logic [AW-1:0]        addr1,
  input  logic [DW-1:0]        wdata0,
  input  logic [DW-1:0]        wdata1,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [NUM_PORTS-1:0] rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 mem_cs,
  output logic                 mem_oe,
  output logic                 mem_web,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [31:0]          mem_rdata
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

  arb_state_t           state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
  logic                 oe_q, oe_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;

  logic                 own;
  logic                 owned;
  logic                 at_max;
  logic                 hold;
  logic                 evict;
  logic [NUM_PORTS-1:0] pick_req;
  logic [NUM_PORTS-1:0] pick_gnt;
  logic [NUM_PORTS-1:0] gnt_c;

  assign own    = (state_q == OWN1);
  assign owned  = (state_q != IDLE);
  assign at_max = (cnt_q == MAX_CNT);
  assign hold   = owned && req[own] && lock[own] && !(at_max && req[!own]);
  // A burst cut short by MAX_BURST must hand over, even under fixed priority.
  assign evict  = owned && at_max && req[own] && lock[own] && req[!own];
  assign pick_req = req & ~(evict ? (own ? 2'b10 : 2'b01) : 2'b00);

  inout_sram_rr_pick u_pick (
    .req      (pick_req),
    .last_ptr (last_q),
    .gnt      (pick_gnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_c   = '0;
    if (hold) begin
      gnt_c[own] = 1'b1;
      if (!at_max) cnt_d = cnt_q + 8'd1;
    end else begin
      gnt_c   = pick_gnt;
      state_d = IDLE;
      cnt_d   = '0;
      if (pick_gnt[1] && lock[1]) begin
        state_d = OWN1;
        cnt_d   = 8'd1;
      end else if (pick_gnt[0] && lock[0]) begin
        state_d = OWN0;
        cnt_d   = 8'd1;
      end
    end
    if (!rst) gnt_c = '0;
    if (|gnt_c) last_d = gnt_c[1];
    rvalid_d = gnt_c & ~we;
    oe_d     = |rvalid_d;
    addr_d   = gnt_c[1] ? addr1  : (gnt_c[0] ? addr0  : addr_q);
    wdata_d  = gnt_c[1] ? wdata1 : (gnt_c[0] ? wdata0 : wdata_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      rvalid_q <= '0;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      oe_q     <= oe_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign gnt       = gnt_c;
  assign mem_cs    = |gnt_c;
  assign mem_web   = ~|(gnt_c & we);
  assign mem_addr  = addr_d;
  assign mem_wdata = wdata_d;
  // Gating by rst drops a read that was in flight when reset arrived.
  assign rvalid    = rvalid_q & {NUM_PORTS{rst}};
  assign mem_oe    = oe_q & rst;
  assign rdata     = mem_rdata[DW-1:0];

  generate
    if (DW < 32) begin : g_rdata_hi
      logic unused_rdata_hi;
      assign unused_rdata_hi = ^mem_rdata[31:DW];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_inout_sram_arbiter.sv
// ============================================================================
// Module  : tb_inout_sram_arbiter
// Purpose : Cycle table plus hand sequences for inout_sram_arbiter (MAX_BURST=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inout_sram_arbiter;

`ifdef INOUT_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we, lock;
  logic [17:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  gnt, rvalid;
  logic [15:0] rdata;
  logic        mem_cs, mem_oe, mem_web;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [15:0] mem [0:(1<<18)-1];
  logic [15:0] rd_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inout_sram_arbiter #(.AW(18), .DW(16), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_web(mem_web),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_cs) begin
      if (!mem_web) mem[mem_addr] <= mem_wdata;
      else          rd_q <= mem[mem_addr];
    end
  end
  assign mem_rdata = {16'hA5A5, rd_q};

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  lock;
    logic [17:0] a0;
    logic [15:0] wd0;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic        chk_rd;
    logic [15:0] rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] rq, input logic [1:0] w,
                     input logic [1:0] lk, input logic [17:0] a0, input logic [15:0] wd,
                     input logic [1:0] g, input logic [1:0] rv,
                     input logic crd, input logic [15:0] rd);
    vec_t v;
    v.rst = r; v.req = rq; v.we = w; v.lock = lk; v.a0 = a0; v.wd0 = wd;
    v.gnt = g; v.rv = rv; v.chk_rd = crd; v.rd = rd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    logic [17:0] hold_addr;
    logic        hold_ok;
    logic [1:0]  alt;
    int          lat;

    alt = FIXED ? 2'b01 : 2'b10;
    hold_ok = 1'b0;
    hold_addr = '0;
    rd_q = '0;
    rst = 1'b0; req = '0; we = '0; lock = '0;
    addr0 = 18'h00010; addr1 = 18'h00020; wdata0 = '0; wdata1 = 16'h1234;

    //   rst  req    we     lock   a0         wd0       gnt    rvalid crd rd
    add(1'b0, 2'b11, 2'b00, 2'b00, 18'h00010, 16'h0000, 2'b00, 2'b00, 0, 16'h0); // 0 reset
    add(1'b0, 2'b11, 2'b00, 2'b00, 18'h00010, 16'h0000, 2'b00, 2'b00, 0, 16'h0); // 1
    add(1'b1, 2'b11, 2'b00, 2'b00, 18'h00010, 16'h0000, 2'b01, 2'b00, 0, 16'h0); // 2 contention
    add(1'b1, 2'b11, 2'b00, 2'b00, 18'h00010, 16'h0000, alt,   2'b01, 0, 16'h0); // 3
    add(1'b1, 2'b11, 2'b00, 2'b00, 18'h00010, 16'h0000, 2'b01, alt,   0, 16'h0); // 4
    add(1'b1, 2'b11, 2'b00, 2'b00, 18'h00010, 16'h0000, alt,   2'b01, 0, 16'h0); // 5
    add(1'b1, 2'b00, 2'b00, 2'b00, 18'h00010, 16'h0000, 2'b00, alt,   0, 16'h0); // 6
    add(1'b1, 2'b01, 2'b01, 2'b00, 18'h08000, 16'hBEEF, 2'b01, 2'b00, 0, 16'h0); // 7 write
    add(1'b1, 2'b01, 2'b00, 2'b00, 18'h08000, 16'hBEEF, 2'b01, 2'b00, 0, 16'h0); // 8 read back
    add(1'b1, 2'b00, 2'b00, 2'b00, 18'h08000, 16'hBEEF, 2'b00, 2'b01, 1, 16'hBEEF); // 9
    add(1'b0, 2'b00, 2'b00, 2'b00, 18'h00010, 16'h0000, 2'b00, 2'b00, 0, 16'h0); // 10 reset
    add(1'b1, 2'b11, 2'b00, 2'b01, 18'h00010, 16'h0000, 2'b01, 2'b00, 0, 16'h0); // 11 burst
    add(1'b1, 2'b11, 2'b00, 2'b01, 18'h00010, 16'h0000, 2'b01, 2'b01, 0, 16'h0); // 12
    add(1'b1, 2'b11, 2'b00, 2'b01, 18'h00010, 16'h0000, 2'b01, 2'b01, 0, 16'h0); // 13
    add(1'b1, 2'b11, 2'b00, 2'b01, 18'h00010, 16'h0000, 2'b01, 2'b01, 0, 16'h0); // 14
    add(1'b1, 2'b11, 2'b00, 2'b01, 18'h00010, 16'h0000, 2'b10, 2'b01, 0, 16'h0); // 15 max hit
    add(1'b1, 2'b11, 2'b00, 2'b01, 18'h00010, 16'h0000, 2'b01, 2'b10, 0, 16'h0); // 16
    add(1'b1, 2'b01, 2'b00, 2'b01, 18'h00010, 16'h0000, 2'b01, 2'b01, 0, 16'h0); // 17 solo burst
    add(1'b1, 2'b01, 2'b00, 2'b01, 18'h00010, 16'h0000, 2'b01, 2'b01, 0, 16'h0); // 18
    add(1'b1, 2'b01, 2'b00, 2'b01, 18'h00010, 16'h0000, 2'b01, 2'b01, 0, 16'h0); // 19
    add(1'b1, 2'b01, 2'b00, 2'b01, 18'h00010, 16'h0000, 2'b01, 2'b01, 0, 16'h0); // 20 saturated
    add(1'b1, 2'b01, 2'b00, 2'b01, 18'h00010, 16'h0000, 2'b01, 2'b01, 0, 16'h0); // 21
    add(1'b1, 2'b11, 2'b00, 2'b01, 18'h00010, 16'h0000, 2'b10, 2'b01, 0, 16'h0); // 22 handover
    add(1'b1, 2'b00, 2'b00, 2'b00, 18'h00010, 16'h0000, 2'b00, 2'b10, 0, 16'h0); // 23
    add(1'b1, 2'b10, 2'b00, 2'b00, 18'h00010, 16'h0000, 2'b10, 2'b00, 0, 16'h0); // 24 p1 read
    add(1'b0, 2'b00, 2'b00, 2'b00, 18'h00010, 16'h0000, 2'b00, 2'b00, 0, 16'h0); // 25 dropped
    add(1'b1, 2'b00, 2'b00, 2'b00, 18'h00010, 16'h0000, 2'b00, 2'b00, 0, 16'h0); // 26
    add(1'b1, 2'b10, 2'b00, 2'b10, 18'h00010, 16'h0000, 2'b10, 2'b00, 0, 16'h0); // 27 p1 lock
    add(1'b1, 2'b11, 2'b00, 2'b00, 18'h00010, 16'h0000, 2'b01, 2'b10, 0, 16'h0); // 28 unlock
    add(1'b1, 2'b00, 2'b00, 2'b00, 18'h00010, 16'h0000, 2'b00, 2'b01, 0, 16'h0); // 29

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; req = vecs[i].req; we = vecs[i].we; lock = vecs[i].lock;
      addr0 = vecs[i].a0; wdata0 = vecs[i].wd0;
      @(negedge clk);
      chk("gnt",     i, {30'd0, gnt},     {30'd0, vecs[i].gnt});
      chk("rvalid",  i, {30'd0, rvalid},  {30'd0, vecs[i].rv});
      chk("mem_cs",  i, {31'd0, mem_cs},  {31'd0, |vecs[i].gnt});
      chk("mem_web", i, {31'd0, mem_web}, {31'd0, ~|(vecs[i].gnt & vecs[i].we)});
      chk("mem_oe",  i, {31'd0, mem_oe},  {31'd0, |vecs[i].rv});
      if (vecs[i].gnt != 2'b00) begin
        hold_addr = vecs[i].gnt[1] ? addr1 : vecs[i].a0;
        hold_ok = 1'b1;
        chk("mem_addr",  i, {14'd0, mem_addr}, {14'd0, hold_addr});
        chk("mem_wdata", i, {16'd0, mem_wdata},
            {16'd0, (vecs[i].gnt[1] ? wdata1 : vecs[i].wd0)});
      end else if (hold_ok) begin
        chk("mem_addr_hold", i, {14'd0, mem_addr}, {14'd0, hold_addr});
      end
      if (vecs[i].chk_rd)
        chk("rdata", i, {16'd0, rdata}, {16'd0, vecs[i].rd});
    end

    // Port 1 read latency: rvalid[1] exactly one cycle after the grant, single pulse.
    @(posedge clk); #1;
    req = 2'b10; we = 2'b00; lock = 2'b00;
    @(negedge clk);
    chk("lat_gnt", 100, {30'd0, gnt}, 32'd2);
    @(posedge clk); #1;
    req = 2'b00;
    lat = 1;
    while (!rvalid[1] && lat < 4) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("lat_cycles", 101, lat, 1);
    chk("lat_rvalid", 102, {30'd0, rvalid}, 32'd2);
    @(posedge clk); #1;
    chk("lat_pulse", 103, {30'd0, rvalid}, 32'd0);

    // Port 1 write then read back through port 1.
    req = 2'b10; we = 2'b10; addr1 = 18'h00123; wdata1 = 16'hC0DE;
    @(negedge clk);
    chk("p1_web", 104, {31'd0, mem_web}, 32'd0);
    @(posedge clk); #1;
    we = 2'b00;
    @(posedge clk); #1;
    req = 2'b00;
    chk("p1_rvalid", 105, {30'd0, rvalid}, 32'd2);
    chk("p1_rdata", 106, {16'd0, rdata}, 32'h0000C0DE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
